// File: rtl/hazard_forward_controller.sv
`default_nettype none
// ============================================================================
// Module   : hazard_forward_controller
// Purpose  : Load-use stall, operand forwarding selects and taken-branch
//            IF/ID flush for a 5-stage ARM pipeline. Keeps a shadow
//            pipeline of destination tags for the EX, MEM and WB stages.
// Options  : HAZARD_PERF_CNT_EN adds saturating stall/flush event counters.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_forward_controller #(
  parameter int REG_W  = 4,
  parameter int PC_REG = 15,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_use_rn,
  input  logic             id_use_rm,
  input  logic             id_use_rd,
  input  logic             id_rf_enable,
  input  logic             id_load_inst,
  input  logic             id_branch_taken,
  output logic             stall,
  output logic             flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       fwd_c
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
`endif
);

  localparam logic [REG_W-1:0] PC_IDX = REG_W'(PC_REG);

  typedef struct packed {
    logic             valid;
    logic             rf_en;
    logic             load;
    logic [REG_W-1:0] dest;
  } tag_t;

  tag_t ex_q, mem_q, wb_q;
  tag_t ex_d;

  logic w_load_use;
  logic w_active;

  // An in-flight entry produces register x; the PC is never a forwarding target.
  function automatic logic writes(input tag_t e, input logic [REG_W-1:0] x);
    return e.valid & e.rf_en & (e.dest == x) & (x != PC_IDX);
  endfunction

  // Youngest writer wins; a load still in EX cannot forward (it stalls instead).
  function automatic logic [1:0] fwd_sel(input logic use_f, input logic [REG_W-1:0] idx,
                                         input tag_t ex_e, input tag_t mem_e, input tag_t wb_e);
    logic [1:0] sel;
    sel = 2'b00;
    if (use_f) begin
      if (writes(ex_e, idx) && !ex_e.load) sel = 2'b01;
      else if (writes(mem_e, idx))         sel = 2'b10;
      else if (writes(wb_e, idx))          sel = 2'b11;
    end
    return sel;
  endfunction

  // Hazard detection, forwarding selects and next EX tag, all from current state.
  always_comb begin
    w_load_use = ex_q.load & ((id_use_rn & writes(ex_q, id_rn)) |
                              (id_use_rm & writes(ex_q, id_rm)) |
                              (id_use_rd & writes(ex_q, id_rd)));
    stall    = ~reset & id_valid & w_load_use;
    w_active = ~reset & id_valid & ~stall;
    flush    = w_active & id_branch_taken;
    fwd_a    = 2'b00;
    fwd_b    = 2'b00;
    fwd_c    = 2'b00;
    if (w_active) begin
      fwd_a = fwd_sel(id_use_rn, id_rn, ex_q, mem_q, wb_q);
      fwd_b = fwd_sel(id_use_rm, id_rm, ex_q, mem_q, wb_q);
      fwd_c = fwd_sel(id_use_rd, id_rd, ex_q, mem_q, wb_q);
    end
    // A stalled or empty ID slot becomes a bubble in EX.
    ex_d = '0;
    if (id_valid && !stall) begin
      ex_d.valid = 1'b1;
      ex_d.rf_en = id_rf_enable;
      ex_d.load  = id_load_inst;
      ex_d.dest  = id_rd;
    end
  end

  // Advance the shadow tag pipeline; reset discards every in-flight tag.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  // The load flag only matters while a tag sits in EX.
  logic w_unused_load;
  assign w_unused_load = mem_q.load ^ wb_q.load;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Saturating event counters for stall and flush cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
`else
  // Counters absent: stall and flush are visible only on their own ports.
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_forward_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_forward_controller
// Purpose  : Directed-vector scoreboard bench for hazard_forward_controller.
// Options  : HAZARD_PERF_CNT_EN also checks the stall/flush counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_forward_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [3:0] id_rn, id_rm, id_rd;
  logic       id_use_rn, id_use_rm, id_use_rd;
  logic       id_rf_enable, id_load_inst, id_branch_taken;
  logic       stall, flush;
  logic [1:0] fwd_a, fwd_b, fwd_c;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_count, flush_count;
`endif

  hazard_forward_controller #(.REG_W(4), .PC_REG(15), .CNT_W(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_valid        (id_valid),
    .id_rn           (id_rn),
    .id_rm           (id_rm),
    .id_rd           (id_rd),
    .id_use_rn       (id_use_rn),
    .id_use_rm       (id_use_rm),
    .id_use_rd       (id_use_rd),
    .id_rf_enable    (id_rf_enable),
    .id_load_inst    (id_load_inst),
    .id_branch_taken (id_branch_taken),
    .stall           (stall),
    .flush           (flush),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .fwd_c           (fwd_c)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_count     (stall_count),
    .flush_count     (flush_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [7:0]  outs;   // {stall, flush, fwd_a, fwd_b, fwd_c}
    logic [15:0] scnt;
    logic [15:0] fcnt;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   run_s = 0;
  int   run_f = 0;

  // Monitor: one expected entry per driven cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      logic [7:0] act;
      e   = sb.pop_front();
      act = {stall, flush, fwd_a, fwd_b, fwd_c};
      total++;
      if (act !== e.outs) begin
        bad++;
        $display("FAIL %s: got s=%b f=%b a=%b b=%b c=%b want s=%b f=%b a=%b b=%b c=%b",
                 e.name, act[7], act[6], act[5:4], act[3:2], act[1:0],
                 e.outs[7], e.outs[6], e.outs[5:4], e.outs[3:2], e.outs[1:0]);
      end
`ifdef HAZARD_PERF_CNT_EN
      total++;
      if (stall_count !== e.scnt || flush_count !== e.fcnt) begin
        bad++;
        $display("FAIL %s_cnt: got stall_count=%0d flush_count=%0d want %0d %0d",
                 e.name, stall_count, flush_count, e.scnt, e.fcnt);
      end
`endif
    end
  end

  // Drive one ID-stage cycle and queue its hand-computed response.
  task automatic step(input string nm, input logic rst, input logic v,
                      input logic [3:0] rn, input logic [3:0] rm, input logic [3:0] rd,
                      input logic urn, input logic urm, input logic urd,
                      input logic rfen, input logic ld, input logic br,
                      input logic es, input logic ef,
                      input logic [1:0] ea, input logic [1:0] eb, input logic [1:0] ec);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; id_valid = v; id_rn = rn; id_rm = rm; id_rd = rd;
    id_use_rn = urn; id_use_rm = urm; id_use_rd = urd;
    id_rf_enable = rfen; id_load_inst = ld; id_branch_taken = br;
    e.name = nm;
    e.outs = {es, ef, ea, eb, ec};
    e.scnt = 16'(run_s);
    e.fcnt = 16'(run_f);
    sb.push_back(e);
    if (rst) begin
      run_s = 0;
      run_f = 0;
    end else begin
      run_s += int'(es);
      run_f += int'(ef);
    end
  endtask

  initial begin
    reset = 1'b1; id_valid = 1'b0; id_rn = '0; id_rm = '0; id_rd = '0;
    id_use_rn = 1'b0; id_use_rm = 1'b0; id_use_rd = 1'b0;
    id_rf_enable = 1'b0; id_load_inst = 1'b0; id_branch_taken = 1'b0;
    @(posedge clk);
    //    name             rst v  rn  rm  rd  urn urm urd rf ld br  s  f  a  b  c
    step("rst_hold",       1, 1,  1,  0,  0,  1,  0,  0,  1, 0, 1, 0, 0, 0, 0, 0);
    step("ldr_r1",         0, 1, 13,  0,  1,  1,  0,  0,  1, 1, 0, 0, 0, 0, 0, 0);
    step("lu_stall",       0, 1,  1,  3,  2,  1,  1,  0,  1, 0, 0, 1, 0, 0, 0, 0);
    step("lu_fwd_mem",     0, 1,  1,  3,  2,  1,  1,  0,  1, 0, 0, 0, 0, 2, 0, 0);
    step("add_r4",         0, 1,  2,  2,  4,  1,  0,  0,  1, 0, 0, 0, 0, 1, 0, 0);
    step("sub_ex_fwd",     0, 1,  4,  4,  5,  1,  1,  0,  1, 0, 0, 0, 0, 1, 1, 0);
    step("bubble_in",      0, 0,  4,  4,  5,  1,  1,  1,  1, 0, 1, 0, 0, 0, 0, 0);
    step("str_wb_fwd",     0, 1,  4,  4,  5,  1,  1,  1,  0, 0, 0, 0, 0, 3, 3, 2);
    step("mov_r6",         0, 1,  0,  0,  6,  0,  0,  0,  1, 0, 0, 0, 0, 0, 0, 0);
    step("add_r6",         0, 1,  6,  0,  6,  1,  0,  0,  1, 0, 0, 0, 0, 1, 0, 0);
    step("orr_r6",         0, 1,  6,  0,  6,  1,  0,  0,  1, 0, 0, 0, 0, 1, 0, 0);
    step("youngest",       0, 1,  6,  6,  7,  1,  1,  0,  1, 0, 0, 0, 0, 1, 1, 0);
    step("mem_over_wb",    0, 1,  6,  7,  8,  1,  1,  0,  1, 0, 0, 0, 0, 2, 1, 0);
    step("ldr_pc",         0, 1,  0,  0, 15,  0,  0,  0,  1, 1, 0, 0, 0, 0, 0, 0);
    step("pc_excl",        0, 1, 15,  0, 15,  1,  0,  1,  0, 0, 0, 0, 0, 0, 0, 0);
    step("br_flush",       0, 1,  0,  0,  0,  0,  0,  0,  0, 0, 1, 0, 1, 0, 0, 0);
    step("ldr_r0",         0, 1, 13,  0,  0,  1,  0,  0,  1, 1, 0, 0, 0, 0, 0, 0);
    step("br_stall",       0, 1,  0,  0,  0,  1,  0,  0,  0, 0, 1, 1, 0, 0, 0, 0);
    step("br_late_flush",  0, 1,  0,  0,  0,  1,  0,  0,  0, 0, 1, 0, 1, 2, 0, 0);
    step("ldr_r2",         0, 1, 13,  0,  2,  1,  0,  0,  1, 1, 0, 0, 0, 0, 0, 0);
    step("lu_r2",          0, 1,  2,  0,  3,  1,  0,  0,  1, 0, 0, 1, 0, 0, 0, 0);
    step("rst_mid",        1, 1,  2,  0,  3,  1,  0,  0,  1, 0, 0, 0, 0, 0, 0, 0);
    step("post_rst",       0, 1,  2,  0,  3,  1,  0,  0,  1, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d entries left want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_forward_controller.md
Name: hazard_forward_controller

Overview:
- Sequences the 5-stage ARM pipeline around the ID-stage control decoder: detects load-use hazards, produces operand forwarding selects and issues the IF/ID flush on taken branches.
- Keeps its own shadow pipeline of destination tags for the EX, MEM and WB stages.
- Sits beside the ID/EX pipeline register. Its stall output drives the PC and IF/ID hold, and the NOP mux into EX. Its flush output drives the IF/ID clear.

Parameters:
- REG_W, 4, register-index width.
- PC_REG, 15, register index that is never forwarded.
- CNT_W, 16, width of the optional performance counters.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears all state on the rising edge of clk while high.
- id_valid  in  1  the ID stage holds a real instruction (0 = bubble/NOP).
- id_rn  in  REG_W  source operand A index.
- id_rm  in  REG_W  source operand B index.
- id_rd  in  REG_W  destination index; also the store-data source.
- id_use_rn  in  1  operand A is read.
- id_use_rm  in  1  operand B is read (register offset or shift source).
- id_use_rd  in  1  Rd is read as store data.
- id_rf_enable  in  1  the ID instruction writes the register file (ID_RF_enable from the decoder).
- id_load_inst  in  1  the ID instruction is a load.
- id_branch_taken  in  1  B/BL in ID with its condition passed.
- stall  out  1  hold PC and IF/ID, and inject a NOP into ID/EX.
- flush  out  1  clear IF/ID at the next edge.
- fwd_a  out  2  operand A source: 00 register file, 01 EX result, 10 MEM result, 11 WB result.
- fwd_b  out  2  operand B source, same encoding as fwd_a.
- fwd_c  out  2  store-data source, same encoding as fwd_a.

Behaviour:
- Shadow pipeline: three stage entries, EX, MEM and WB. Each entry holds valid, rf_en, load and dest[REG_W-1:0].
- Shadow pipeline update at each edge, when reset is low:
  - WB takes MEM; MEM takes EX.
  - EX takes the ID fields when id_valid=1 and stall=0.
  - Otherwise EX takes a bubble: all fields 0.
- Reset: all entries are cleared to 0 (valid=0). Reset asserted mid-operation discards all in-flight tags.
- All outputs are forced to 0 while reset=1 and in the cycle in which reset is applied.
- Outputs are combinational from the shadow entries and the ID inputs. There is no added latency: a hazard is flagged in the same cycle the dependent instruction sits in ID.
- Writer-match rule: a stage entry "writes X" when valid & rf_en & dest==X & X!=PC_REG.
- Load-use stall: stall=1 when id_valid=1 and the EX entry is a load that writes any operand ID uses:
  - (id_use_rn and Rn matches), or
  - (id_use_rm and Rm matches), or
  - (id_use_rd and Rd matches).
  - The stall lasts exactly one cycle. The next cycle the load is in MEM and the value is forwarded from MEM (select 10).
- Forward select per operand, only when the operand's use flag is 1, first match wins:
  - EX match and EX is not a load -> 01.
  - MEM match -> 10.
  - WB match -> 11.
  - Otherwise -> 00.
  - When the use flag is 0, or the index is PC_REG, the select is 00.
  - When stall=1, all fwd outputs are 00.
- Flush: flush = id_valid & id_branch_taken & ~stall.
  - On simultaneous stall and branch, stall wins. The branch stays in ID and flush is asserted the following cycle.
  - In the flush cycle the branch itself enters EX normally; only the instruction fetched behind it is cleared.
- Bubble input: id_valid=0 produces no stall, no flush and all fwd = 00.
- A register written by several in-flight stages always selects the youngest writer.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined:
  - Adds output stall_count[CNT_W-1:0] and output flush_count[CNT_W-1:0].
  - Each counter increments by 1 on every edge where stall (respectively flush) is 1.
  - Both counters saturate at all-ones and never wrap.
  - Both reset to 0.
- When undefined: the ports and counters are absent and all other behaviour is identical.

Test Plan:
- Load-use stall: LDR R1 then ADD R2,R1,R3 (use_rn, rn=1) -> stall=1 for exactly 1 cycle and EX receives a bubble; next cycle stall=0 and fwd_a=10.
- Back-to-back ALU dependency: ADD R4 writes R4, then SUB R5,R4,R4 (use_rn, use_rm) -> fwd_a=01 and fwd_b=01. After two intervening NOPs -> fwd_a=11 and fwd_b=11.
- Youngest writer priority: MOV R6 in WB, ADD R6 in MEM, ORR R6 in EX, then ID reads R6 -> fwd_a=01.
- PC exclusion: EX entry with rf_en=1 and dest=15, ID reads Rn=15 -> fwd_a=00 and stall=0.
- Branch flush: taken B in ID -> flush=1 that cycle. Load in EX targeting R0 while the branch has use_rn with Rn=0 -> stall=1 and flush=0; next cycle flush=1.
- Reset mid-operation: load in EX writing R2, ID reads R2, assert reset one cycle -> all outputs 0. After release with ID still reading R2 -> stall=0 and fwd_a=00. With HAZARD_PERF_CNT_EN defined, the counters read 0.
